// File: rtl/rms_window_accum_if.sv
`default_nettype none
// ============================================================================
// Module   : rms_window_accum_if
// Purpose  : Sample-stream and sqrt-handshake bundle for rms_window_accum.
// Revision : 1.0  initial release
// ============================================================================
interface rms_window_accum_if #(
    parameter int DATA_WIDTH = 16,
    parameter int SQ_WIDTH   = 32
);
    logic                           sample_valid;
    logic signed [DATA_WIDTH-1:0]   sample_in;
    logic                           sample_ready;
    logic                           sqrt_start;
    logic        [SQ_WIDTH-1:0]     sqrt_x;
    logic                           sqrt_done;
    logic        [SQ_WIDTH/2-1:0]   sqrt_y;
    logic                           rms_valid;
    logic        [SQ_WIDTH/2-1:0]   rms_out;
    logic                           rms_sat;
    logic                           rms_err;
    logic        [DATA_WIDTH-1:0]   peak_out;

    // Environment side: sample producer, sqrt unit and RMS consumer.
    modport master (
        output sample_valid, sample_in, sqrt_done, sqrt_y,
        input  sample_ready, sqrt_start, sqrt_x, rms_valid, rms_out,
               rms_sat, rms_err, peak_out
    );

    // Accumulator side.
    modport slave (
        input  sample_valid, sample_in, sqrt_done, sqrt_y,
        output sample_ready, sqrt_start, sqrt_x, rms_valid, rms_out,
               rms_sat, rms_err, peak_out
    );
endinterface
`default_nettype wire

// File: rtl/rms_window_accum.sv
`default_nettype none
// ============================================================================
// Module   : rms_window_accum
// Purpose  : Windowed sum-of-squares feeding a sqrt unit; publishes RMS with
//            saturation flag and sqrt response timeout.
// Options  : WATCHDOG_RMS_PEAK_EN - track and publish per-window peak |sample|
// Revision : 1.0  initial release
// ============================================================================
module rms_window_accum #(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_WIN   = 4,
    parameter int SQ_WIDTH   = 32,
    parameter int TIMEOUT    = 64
) (
    input  wire logic        clk,
    input  wire logic        rst,
    rms_window_accum_if.slave bus
);

    localparam int ACC_W = 2*DATA_WIDTH + LOG2_WIN;
    localparam int RES_W = SQ_WIDTH/2;
    localparam int CMP_W = (ACC_W > SQ_WIDTH) ? ACC_W : SQ_WIDTH;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_ACCUM = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    // Largest positive value of the signed sqrt operand.
    localparam logic [CMP_W-1:0] c_SQ_MAX =
        {{(CMP_W-SQ_WIDTH+1){1'b0}}, {(SQ_WIDTH-1){1'b1}}};

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_next;

    logic [ACC_W-1:0]           r_acc;
    logic [LOG2_WIN-1:0]        r_cnt;
    logic [TO_W-1:0]            r_to_cnt;
    logic                       r_sat_pend;

    logic                       r_sample_ready;
    logic                       r_sqrt_start;
    logic [SQ_WIDTH-1:0]        r_sqrt_x;
    logic                       r_rms_valid;
    logic [RES_W-1:0]           r_rms_out;
    logic                       r_rms_sat;
    logic                       r_rms_err;

    logic                       w_ready_nx;
    logic                       w_start_nx;
    logic                       w_valid_nx;
    logic                       w_err_nx;

    logic                       w_accept;
    logic                       w_last;
    logic                       w_done;
    logic                       w_expire;

    logic signed [2*DATA_WIDTH-1:0] w_samp_ext;
    logic signed [2*DATA_WIDTH-1:0] w_sq_s;
    logic [ACC_W-1:0]           w_sq;
    logic [ACC_W-1:0]           w_acc_sum;
    logic [ACC_W-1:0]           w_mean;
    logic [CMP_W-1:0]           w_mean_ext;
    logic                       w_sat;
    logic [SQ_WIDTH-1:0]        w_x;

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    assign w_accept = (r_state == S_ACCUM) && bus.sample_valid;
    assign w_last   = w_accept && (r_cnt == {LOG2_WIN{1'b1}});
    assign w_done   = (r_state == S_WAIT) && bus.sqrt_done;
    // A done in the expiry cycle wins over the timeout.
    assign w_expire = (r_state == S_WAIT) && !bus.sqrt_done &&
                      (r_to_cnt == TO_W'(TIMEOUT - 1));

    // ------------------------------------------------------------------
    // Square and mean-square datapath
    // ------------------------------------------------------------------
    assign w_samp_ext = {{DATA_WIDTH{bus.sample_in[DATA_WIDTH-1]}}, bus.sample_in};
    assign w_sq_s     = w_samp_ext * w_samp_ext;
    assign w_sq       = {{LOG2_WIN{1'b0}}, w_sq_s};
    assign w_acc_sum  = r_acc + w_sq;
    assign w_mean     = w_acc_sum >> LOG2_WIN;
    assign w_mean_ext = CMP_W'(w_mean);
    assign w_sat      = (w_mean_ext > c_SQ_MAX);
    assign w_x        = w_sat ? c_SQ_MAX[SQ_WIDTH-1:0] : w_mean_ext[SQ_WIDTH-1:0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_ACCUM: if (w_last)              w_state_next = S_ISSUE;
            S_ISSUE:                          w_state_next = S_WAIT;
            S_WAIT:  if (w_done || w_expire)  w_state_next = S_ACCUM;
            default:                          w_state_next = S_ACCUM;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode (registered one cycle later)
    // ------------------------------------------------------------------
    always_comb begin
        w_ready_nx = (w_state_next == S_ACCUM);
        w_start_nx = (w_state_next == S_ISSUE);
        w_valid_nx = w_done;
        w_err_nx   = w_expire;
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc          <= '0;
            r_cnt          <= '0;
            r_to_cnt       <= '0;
            r_sat_pend     <= 1'b0;
            r_sample_ready <= 1'b1;
            r_sqrt_start   <= 1'b0;
            r_sqrt_x       <= '0;
            r_rms_valid    <= 1'b0;
            r_rms_out      <= '0;
            r_rms_sat      <= 1'b0;
            r_rms_err      <= 1'b0;
        end else begin
            r_sample_ready <= w_ready_nx;
            r_sqrt_start   <= w_start_nx;
            r_rms_valid    <= w_valid_nx;
            r_rms_err      <= w_err_nx;

            if (w_accept) begin
                r_acc <= w_acc_sum;
                r_cnt <= r_cnt + LOG2_WIN'(1);
            end

            // Operand is captured from the final sum so it is valid with start.
            if (w_last) begin
                r_sqrt_x   <= w_x;
                r_sat_pend <= w_sat;
            end

            if (r_state == S_WAIT) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
                r_to_cnt <= '0;
            end

            if (w_done || w_expire) begin
                r_acc    <= '0;
                r_cnt    <= '0;
                r_to_cnt <= '0;
            end

            if (w_done) begin
                r_rms_out <= bus.sqrt_y;
                r_rms_sat <= r_sat_pend;
            end
        end
    end

    assign bus.sample_ready = r_sample_ready;
    assign bus.sqrt_start   = r_sqrt_start;
    assign bus.sqrt_x       = r_sqrt_x;
    assign bus.rms_valid    = r_rms_valid;
    assign bus.rms_out      = r_rms_out;
    assign bus.rms_sat      = r_rms_sat;
    assign bus.rms_err      = r_rms_err;

`ifdef WATCHDOG_RMS_PEAK_EN
    logic [DATA_WIDTH-1:0] w_neg;
    logic [DATA_WIDTH-1:0] w_abs;
    logic [DATA_WIDTH-1:0] r_peak;
    logic [DATA_WIDTH-1:0] r_peak_out;

    // Unsigned magnitude: the most negative sample maps to 2^(DATA_WIDTH-1).
    assign w_neg = ~bus.sample_in + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    assign w_abs = bus.sample_in[DATA_WIDTH-1] ? w_neg : bus.sample_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_peak     <= '0;
            r_peak_out <= '0;
        end else begin
            if (w_done || w_expire) begin
                r_peak <= '0;
            end else if (w_accept && (w_abs > r_peak)) begin
                r_peak <= w_abs;
            end
            if (w_done) begin
                r_peak_out <= r_peak;
            end
        end
    end

    assign bus.peak_out = r_peak_out;
`else
    assign bus.peak_out = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rms_window_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_rms_window_accum
// Purpose  : Self-checking bench; two instances (SQ_WIDTH 32 and 24) share
//            stimulus and are compared against a window-level arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_rms_window_accum;

`ifdef WATCHDOG_RMS_PEAK_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    rms_window_accum_if #(.DATA_WIDTH(16), .SQ_WIDTH(32)) if0 ();
    rms_window_accum_if #(.DATA_WIDTH(16), .SQ_WIDTH(24)) if1 ();

    rms_window_accum #(.DATA_WIDTH(16), .LOG2_WIN(4), .SQ_WIDTH(32), .TIMEOUT(64)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    rms_window_accum #(.DATA_WIDTH(16), .LOG2_WIN(4), .SQ_WIDTH(24), .TIMEOUT(64)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic signed [15:0] win [16];
    longint exp_x0, exp_x1, exp_y0, exp_y1, exp_pk;
    bit     exp_sat0, exp_sat1;
    longint last_y0, last_y1, last_pk;
    bit     last_sat0, last_sat1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint isqrt(input longint x);
        longint r = 0;
        for (int b = 16; b >= 0; b--) begin
            longint t = r | (longint'(1) << b);
            if (t * t <= x) r = t;
        end
        return r;
    endfunction

    function automatic longint peak_expect(input longint pk);
        return PEAK_EN ? pk : 0;
    endfunction

    task automatic compute_model();
        longint acc = 0;
        longint mean;
        exp_pk = 0;
        for (int i = 0; i < 16; i++) begin
            longint v = longint'(win[i]);
            longint a = (v < 0) ? -v : v;
            acc += v * v;
            if (a > exp_pk) exp_pk = a;
        end
        mean     = acc / 16;
        exp_sat0 = (mean > 64'd2147483647);
        exp_x0   = exp_sat0 ? 64'd2147483647 : mean;
        exp_sat1 = (mean > 64'd8388607);
        exp_x1   = exp_sat1 ? 64'd8388607 : mean;
        exp_y0   = isqrt(exp_x0);
        exp_y1   = isqrt(exp_x1);
    endtask

    task automatic set_sample(input logic v, input logic signed [15:0] s);
        if0.sample_valid = v;  if0.sample_in = s;
        if1.sample_valid = v;  if1.sample_in = s;
    endtask

    task automatic set_done(input logic d, input logic [15:0] y0, input logic [11:0] y1);
        if0.sqrt_done = d;  if0.sqrt_y = y0;
        if1.sqrt_done = d;  if1.sqrt_y = y1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ready"},  if0.sample_ready, 1);
        chk({tag, "_start"},  if0.sqrt_start, 0);
        chk({tag, "_valid"},  if0.rms_valid, 0);
        chk({tag, "_sat"},    if0.rms_sat, 0);
        chk({tag, "_err"},    if0.rms_err, 0);
        chk({tag, "_x"},      if0.sqrt_x, 0);
        chk({tag, "_rms"},    if0.rms_out, 0);
        chk({tag, "_peak"},   if0.peak_out, 0);
        chk({tag, "_ready1"}, if1.sample_ready, 1);
        chk({tag, "_x1"},     if1.sqrt_x, 0);
        last_y0 = 0; last_y1 = 0; last_pk = 0; last_sat0 = 0; last_sat1 = 0;
    endtask

    // Offers win[0..n-1]; each sample is accepted on the posedge after it is driven.
    task automatic send_samples(input int n, input int gap_max);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                @(negedge clk);
                set_sample(1'b0, 16'sd0);
                chk("ready_idle", if0.sample_ready, 1);
            end
            @(negedge clk);
            set_sample(1'b1, win[i]);
            chk("ready_accum", if0.sample_ready, 1);
        end
    endtask

    // Plays the sqrt unit: returns done at WAIT cycle index k, or never.
    task automatic issue_and_respond(input int k, input bit give_done);
        @(negedge clk);
        set_sample(1'b0, 16'sd0);
        chk("start0", if0.sqrt_start, 1);
        chk("x0", if0.sqrt_x, exp_x0);
        chk("ready_issue", if0.sample_ready, 0);
        chk("start1", if1.sqrt_start, 1);
        chk("x1", if1.sqrt_x, exp_x1);
        if (give_done) begin
            for (int idx = 0; idx <= k; idx++) begin
                @(negedge clk);
                chk("wait_quiet", {if0.rms_valid, if0.rms_err, if0.sqrt_start, if0.sample_ready}, 0);
                if (idx == k) set_done(1'b1, 16'(exp_y0), 12'(exp_y1));
            end
            @(negedge clk);
            set_done(1'b0, 16'd0, 12'd0);
            chk("valid0", if0.rms_valid, 1);
            chk("err0_ok", if0.rms_err, 0);
            chk("rms0", if0.rms_out, exp_y0);
            chk("sat0", if0.rms_sat, exp_sat0);
            chk("peak", if0.peak_out, peak_expect(exp_pk));
            chk("ready_back", if0.sample_ready, 1);
            chk("x0_hold", if0.sqrt_x, exp_x0);
            chk("rms1", if1.rms_out, exp_y1);
            chk("sat1", if1.rms_sat, exp_sat1);
            last_y0 = exp_y0; last_y1 = exp_y1; last_pk = peak_expect(exp_pk);
            last_sat0 = exp_sat0; last_sat1 = exp_sat1;
            @(negedge clk);
            chk("valid0_pulse", if0.rms_valid, 0);
        end else begin
            for (int idx = 0; idx < 64; idx++) begin
                @(negedge clk);
                chk("wait_quiet_to", {if0.rms_valid, if0.rms_err, if0.sqrt_start, if0.sample_ready}, 0);
            end
            @(negedge clk);
            chk("err0", if0.rms_err, 1);
            chk("err1", if1.rms_err, 1);
            chk("valid0_to", if0.rms_valid, 0);
            chk("rms0_keep", if0.rms_out, last_y0);
            chk("sat0_keep", if0.rms_sat, last_sat0);
            chk("peak_keep", if0.peak_out, last_pk);
            chk("ready_to", if0.sample_ready, 1);
            @(negedge clk);
            chk("err0_pulse", if0.rms_err, 0);
        end
    endtask

    task automatic random_window();
        for (int i = 0; i < 16; i++) begin
            logic signed [15:0] t = 16'($urandom);
            win[i] = t >>> $urandom_range(12, 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_sample(1'b0, 16'sd0);
        set_done(1'b0, 16'd0, 12'd0);
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;

        // Constant +100, done 17 cycles after the start pulse
        for (int i = 0; i < 16; i++) win[i] = 16'sd100;
        compute_model();
        send_samples(16, 0);
        issue_and_respond(16, 1'b1);

        // Alternating +3 / -4
        for (int i = 0; i < 16; i++) win[i] = (i % 2 == 0) ? 16'sd3 : -16'sd4;
        compute_model();
        send_samples(16, 2);
        issue_and_respond($urandom_range(30, 0), 1'b1);

        // Most negative sample: exact in 32-bit, clamped in 24-bit instance
        for (int i = 0; i < 16; i++) win[i] = -16'sd32768;
        compute_model();
        send_samples(16, 1);
        issue_and_respond(5, 1'b1);

        // Random windows
        for (int w = 0; w < 4; w++) begin
            random_window();
            compute_model();
            send_samples(16, 3);
            issue_and_respond($urandom_range(40, 0), 1'b1);
        end

        // Timeout, then a fresh window must start from an empty accumulator
        random_window();
        compute_model();
        send_samples(16, 1);
        issue_and_respond(0, 1'b0);
        random_window();
        compute_model();
        send_samples(16, 1);
        issue_and_respond($urandom_range(20, 0), 1'b1);

        // Done in the expiry cycle counts as success
        random_window();
        compute_model();
        send_samples(16, 0);
        issue_and_respond(63, 1'b1);

        // Reset part-way through a window
        for (int i = 0; i < 16; i++) win[i] = 16'sd9;
        send_samples(8, 1);
        @(negedge clk);
        set_sample(1'b0, 16'sd0);
        rst = 1'b1;
        @(negedge clk);
        check_reset("rst_mid_accum");
        rst = 1'b0;

        // Reset in WAIT, then a stale done must be ignored
        for (int i = 0; i < 16; i++) win[i] = 16'sd7;
        compute_model();
        send_samples(16, 0);
        @(negedge clk);
        set_sample(1'b0, 16'sd0);
        chk("start_pre_rst", if0.sqrt_start, 1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("rst_mid_wait");
        rst = 1'b0;
        set_done(1'b1, 16'd7, 12'd7);
        @(negedge clk);
        set_done(1'b0, 16'd0, 12'd0);
        chk("stale_done_valid", if0.rms_valid, 0);
        chk("stale_done_ready", if0.sample_ready, 1);
        chk("stale_done_rms", if0.rms_out, 0);

        // Clean window of +5 after the resets
        for (int i = 0; i < 16; i++) win[i] = 16'sd5;
        compute_model();
        send_samples(16, 1);
        issue_and_respond($urandom_range(20, 0), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
